// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory handshake, decode handoff and PC select inputs.
interface mips_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        pcsrc;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] fetch_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, funct, pc, pcplus4, fetch_count,
        input  imem_ack, imem_rdata, instr_ready, pcsrc, jump, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, funct, pc, pcplus4, fetch_count,
        output imem_ack, imem_rdata, instr_ready, pcsrc, jump, branch_target
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch: PC register, imem req/ack fetch FSM and next-PC select.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         clk,
    input logic         reset,
    mips_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {START, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] pcplus4;
    logic [31:0] next_pc;

    assign pcplus4 = pc_q + 32'd4;

    // jump outranks pcsrc; low bits of any target are forced to a word boundary
    always_comb begin
        next_pc = pcplus4;
        if (bus.jump)
            next_pc = {pcplus4[31:28], instr_q[25:0], 2'b00};
        else if (bus.pcsrc)
            next_pc = {bus.branch_target[31:2], 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= START;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                START: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state   <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        pc_q    <= next_pc;
                        count_q <= count_q + 32'd1;
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= START;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.pc          = pc_q;
    assign bus.pcplus4     = pcplus4;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: fetch handshake, stalls, branch/jump select, wrap, reset abort.
module tb_mips_fetch_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mips_fetch_unit_if f ();

    mips_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack the pending fetch immediately, then accept it with the given select inputs.
    task automatic fetch_accept(input logic [31:0] word, input logic pcs, input logic jmp,
                                input logic [31:0] bt);
        f.imem_ack   = 1'b1;
        f.imem_rdata = word;
        tick();
        f.imem_ack      = 1'b0;
        f.pcsrc         = pcs;
        f.jump          = jmp;
        f.branch_target = bt;
        f.instr_ready   = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        f.pcsrc       = 1'b0;
        f.jump        = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        f.imem_ack = 1'b0;
        f.imem_rdata = '0;
        f.instr_ready = 1'b0;
        f.pcsrc = 1'b0;
        f.jump = 1'b0;
        f.branch_target = '0;
        tick();
        tick();
        chk("rst_req", {31'd0, f.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, f.instr_valid}, 32'd0);
        chk("rst_pc", f.pc, 32'h0);
        chk("rst_instr", f.instr, 32'h0);
        chk("rst_count", f.fetch_count, 32'h0);

        // 1: zero-wait fetch at 0x0
        reset = 1'b0;
        tick();
        chk("t1_req", {31'd0, f.imem_req}, 32'd1);
        chk("t1_addr", f.imem_addr, 32'h0);
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'h2010_0005;
        tick();
        f.imem_ack = 1'b0;
        chk("t1_valid", {31'd0, f.instr_valid}, 32'd1);
        chk("t1_op", {26'd0, f.op}, 32'h08);
        chk("t1_req_hold", {31'd0, f.imem_req}, 32'd0);
        f.instr_ready = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        chk("t1_pc", f.pc, 32'h4);
        chk("t1_count", f.fetch_count, 32'd1);
        chk("t1_valid_off", {31'd0, f.instr_valid}, 32'd0);

        // 2: three wait cycles before ack
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", {31'd0, f.imem_req}, 32'd1);
            chk("t2_addr", f.imem_addr, 32'h4);
            chk("t2_valid", {31'd0, f.instr_valid}, 32'd0);
            tick();
        end
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'h1234_5678;
        tick();
        f.imem_ack = 1'b0;
        chk("t2_instr", f.instr, 32'h1234_5678);
        chk("t2_valid_on", {31'd0, f.instr_valid}, 32'd1);
        chk("t2_count", f.fetch_count, 32'd1);

        // 3: stalled HOLD ignores pcsrc/jump and spurious acks
        for (int i = 0; i < 5; i++) begin
            f.pcsrc = i[0];
            f.jump = ~i[0];
            f.branch_target = 32'hABCD_0000;
            f.imem_ack = 1'b1;
            f.imem_rdata = 32'hDEAD_0000 + i;
            tick();
            chk("t3_pc", f.pc, 32'h4);
            chk("t3_instr", f.instr, 32'h1234_5678);
            chk("t3_count", f.fetch_count, 32'd1);
            chk("t3_req", {31'd0, f.imem_req}, 32'd0);
        end
        f.imem_ack = 1'b0;
        f.pcsrc = 1'b1;
        f.jump = 1'b0;
        f.branch_target = 32'h0000_0040;
        f.instr_ready = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        f.pcsrc = 1'b0;
        chk("t3_branch_pc", f.pc, 32'h40);
        chk("t3_count2", f.fetch_count, 32'd2);

        // 4: R-type at 0x40, branch with unaligned target
        chk("t4_addr", f.imem_addr, 32'h40);
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'h0232_8020;
        tick();
        f.imem_ack = 1'b0;
        chk("t4_funct", {26'd0, f.funct}, 32'h20);
        chk("t4_op", {26'd0, f.op}, 32'h00);
        chk("t4_pcplus4", f.pcplus4, 32'h44);
        f.pcsrc = 1'b1;
        f.branch_target = 32'h0000_0083;
        f.instr_ready = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        f.pcsrc = 1'b0;
        chk("t4_next_addr", f.imem_addr, 32'h80);
        chk("t4_count", f.fetch_count, 32'd3);

        // 5: jump wins over pcsrc
        fetch_accept(32'h0000_0000, 1'b1, 1'b0, 32'h1000_0010);
        chk("t5_pc_pre", f.pc, 32'h1000_0010);
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'h0800_0010;
        tick();
        f.imem_ack = 1'b0;
        chk("t5_op", {26'd0, f.op}, 32'h02);
        chk("t5_pcplus4", f.pcplus4, 32'h1000_0014);
        f.jump = 1'b1;
        f.pcsrc = 1'b1;
        f.branch_target = 32'h1234_5678;
        f.instr_ready = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        f.jump = 1'b0;
        f.pcsrc = 1'b0;
        chk("t5_jump_pc", f.pc, 32'h1000_0040);
        chk("t5_count", f.fetch_count, 32'd5);

        // 6: wrap from top of address space, then reset mid-FETCH
        fetch_accept(32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("t6_pc_top", f.pc, 32'hFFFF_FFFC);
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'h0000_0000;
        tick();
        f.imem_ack = 1'b0;
        chk("t6_pcplus4", f.pcplus4, 32'h0);
        f.instr_ready = 1'b1;
        tick();
        f.instr_ready = 1'b0;
        chk("t6_wrap_pc", f.pc, 32'h0);
        chk("t6_count", f.fetch_count, 32'd7);
        chk("t6_in_fetch", {31'd0, f.imem_req}, 32'd1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_count", f.fetch_count, 32'd0);
        chk("t6_rst_req", {31'd0, f.imem_req}, 32'd0);
        f.imem_ack = 1'b1;
        f.imem_rdata = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0;
        tick();
        f.imem_ack = 1'b0;
        chk("t6_late_ack_valid", {31'd0, f.instr_valid}, 32'd0);
        chk("t6_late_ack_instr", f.instr, 32'h0);
        chk("t6_late_ack_req", {31'd0, f.imem_req}, 32'd1);
        chk("t6_final_pc", f.pc, 32'h0);
        chk("t6_final_count", f.fetch_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch side of the MIPS core: holds the PC, requests instruction words from instruction memory over a req/ack handshake, and presents the fetched word to the Controller.
- Drives the Controller's op and funct inputs. Consumes the Controller's pcsrc and jump outputs to select the next PC.
- Sits between instruction memory and the Controller/datapath decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word-aligned fetch address, equal to pc
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
instr_valid  output  1  instr/op/funct hold a valid instruction
instr_ready  input  1  decode stage accepts the instruction this cycle
instr  output  32  registered instruction word
op  output  6  instr[31:26], to Controller op
funct  output  6  instr[5:0], to Controller funct
pcsrc  input  1  from Controller: take branch for the instruction being accepted
jump  input  1  from Controller: instruction being accepted is J
branch_target  input  32  pcbranch from datapath (pcplus4 + signimm<<2)
pc  output  32  address of the current instruction
pcplus4  output  32  pc + 4, combinational, modulo 2^32
fetch_count  output  32  number of accepted instructions

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = START
  - pc = RESET_PC
  - instr = 0
  - fetch_count = 0
  - imem_req = 0, instr_valid = 0
- FSM has three states: START, FETCH, HOLD.
- START:
  - imem_req = 0, instr_valid = 0.
  - Unconditionally moves to FETCH on the next edge.
  - An imem_ack seen in START is ignored; this covers an ack still in flight when reset hit mid-fetch.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until ack.
  - When imem_ack = 1, the edge latches instr <= imem_rdata and moves to HOLD.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
  - instr_valid = 0 throughout FETCH.
- HOLD:
  - imem_req = 0, instr_valid = 1. instr is stable.
  - op and funct are combinational slices of instr, so the Controller sees them the same cycle.
  - While instr_ready = 0, everything holds and pcsrc/jump are ignored.
  - When instr_ready = 1 (acceptance), the edge does the following:
    - pc <= next_pc
    - fetch_count <= fetch_count + 1, wrapping modulo 2^32
    - state <= FETCH
- next_pc is evaluated only in the acceptance cycle. Priority:
  1. jump = 1: {pcplus4[31:28], instr[25:0], 2'b00}
  2. else pcsrc = 1: {branch_target[31:2], 2'b00}
  3. else: pcplus4
- jump has priority when both jump and pcsrc are asserted.
- pc[1:0] is always 00. Low bits of branch_target are discarded.
- pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no error indication.
- Throughput: at most one instruction every 2 cycles (FETCH then HOLD).
- Latency: an ack at edge N gives instr_valid = 1 in the cycle after edge N.
- imem_ack is ignored outside FETCH.
- imem_ack and instr_ready are independent; no simultaneous-event conflict exists because they act in different states.
- Reset asserted in any state aborts immediately. No partial update of pc or fetch_count survives.

Test Plan:
1. Reset, then release with 0-wait memory returning 32'h2010_0005 at 0x0.
   - imem_req rises 1 cycle after reset release, imem_addr = 0.
   - instr_valid follows, op = 6'b001000.
   - With instr_ready = 1: pc = 4, fetch_count = 1.
2. Memory acks 3 cycles after imem_req.
   - imem_req and imem_addr stay constant for all 3 cycles.
   - instr_valid stays 0 until the ack.
   - Exactly one instruction is latched.
3. Hold instr_ready = 0 for 5 cycles in HOLD, toggling pcsrc/jump and driving spurious imem_ack.
   - pc, instr and fetch_count are unchanged.
   - imem_req stays 0.
4. At pc = 0x40, fetch R-type instr 32'h0232_8020 (funct 100000) with pcsrc = 1, branch_target = 0x0000_0083.
   - funct output = 6'b100000.
   - Next imem_addr = 0x0000_0080.
5. At pc = 0x1000_0010, fetch J instr 32'h0800_0010 with jump = 1 and pcsrc = 1.
   - Next pc = 0x1000_0040 (jump wins over pcsrc).
6. Start at pc = 0xFFFF_FFFC, accept a sequential instruction.
   - pc becomes 0x0000_0000.
   - Then assert reset mid-FETCH with an ack arriving in START: the late ack is ignored, pc = RESET_PC, fetch_count = 0.
